// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared constants and helpers for the parametrised up/down counter family.
//   CNT_UP / CNT_DOWN    : meaning of the up_down input
//   MODE_WRAP / MODE_SAT : meaning of the sat_mode input
//   clamp_load()         : limits a load value to the programmed modulus
// ---------------------------------------------------------------------------
package contador_pkg;

   localparam logic CNT_UP    = 1'b1;
   localparam logic CNT_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Widest counter supported; clamp_load works at this width so that one
   // function serves every WIDTH instance.
   localparam int CLAMP_W = 16;

   function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] value,
                                                      input logic [CLAMP_W-1:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/modulo_ff_t_sload.sv
// ---------------------------------------------------------------------------
// modulo_ff_t_sload
// One counter bit: a T flip-flop with synchronous load and count enable.
//   clk       : rising-edge clock
//   clr       : asynchronous active-low reset, forces q to RESET_BIT
//   enable    : allows the toggle input to act
//   toggle    : flip q on the next edge when enabled
//   load      : synchronous load strobe, overrides enable/toggle
//   load_data : value taken on a load
//   q         : stored bit
// ---------------------------------------------------------------------------
module modulo_ff_t_sload #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic enable,
   input  logic toggle,
   input  logic load,
   input  logic load_data,
   output logic q
);

   logic q_q;
   logic q_d;

   // Next-state selection: a load always wins, otherwise the bit flips only
   // when both the counter is enabled and the toggle chain says so.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_data;
      end else if (enable && toggle) begin
         q_d = ~q_q;
      end
   end

   // Bit storage with asynchronous clear to the slice's share of the reset value.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_q <= RESET_BIT;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/modulo_contador_param_up_down_mod.sv
// ---------------------------------------------------------------------------
// modulo_contador_param_up_down_mod
// WIDTH-bit up/down counter over the range 0..MAX_COUNT built from T-FF
// slices, with synchronous load, wrap/saturate mode and registered flags.
//   clk      : rising-edge clock
//   clr      : asynchronous active-low reset (q=RESET_VALUE, tc=0, ovf=0)
//   enable   : count enable; hold when 0
//   up_down  : 1 = count up, 0 = count down
//   load     : synchronous load strobe, highest priority
//   e_load   : load value, clamped to MAX_COUNT
//   sat_mode : 0 = wrap at limits, 1 = saturate at limits
//   clr_ovf  : synchronous clear of the sticky overflow flag
//   q        : current count
//   tc       : one-cycle pulse the cycle after a limit event
//   at_limit : combinational, q is at the limit for the current direction
//   ovf      : sticky, set by any limit event
// ---------------------------------------------------------------------------
module modulo_contador_param_up_down_mod
   import contador_pkg::*;
#(
   parameter int WIDTH       = 7,
   parameter int MAX_COUNT   = (1 << WIDTH) - 1,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] e_load,
   input  logic             sat_mode,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             at_limit,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] borrow;
   logic [WIDTH-1:0] toggle_vec;
   logic [WIDTH-1:0] load_val;
   logic             limit_event;
   logic             tc_q;
   logic             tc_d;
   logic             ovf_q;
   logic             ovf_d;

   assign at_limit    = (up_down == CNT_UP) ? (count_q == MAX_V) : (count_q == '0);
   // A load suppresses the limit event even when the counter sits at a limit.
   assign limit_event = enable && !load && at_limit;

   assign load_val = WIDTH'(clamp_load(CLAMP_W'(e_load), CLAMP_W'(MAX_COUNT)));

   // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign carry[i]  = carry[i-1]  &  count_q[i-1];
      assign borrow[i] = borrow[i-1] & ~count_q[i-1];
   end

   // At a limit the ripple chain is replaced: saturate freezes every bit,
   // wrap flips exactly the bits that turn the current value into the
   // opposite limit (MAX -> 0 going up, 0 -> MAX going down). This is what
   // makes a modulus smaller than 2**WIDTH work.
   always_comb begin
      toggle_vec = (up_down == CNT_UP) ? carry : borrow;
      if (at_limit) begin
         if (sat_mode == MODE_SAT) begin
            toggle_vec = '0;
         end else if (up_down == CNT_UP) begin
            toggle_vec = count_q;
         end else begin
            toggle_vec = MAX_V;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      modulo_ff_t_sload #(
         .RESET_BIT(RESET_V[i])
      ) u_slice (
         .clk       (clk),
         .clr       (clr),
         .enable    (enable),
         .toggle    (toggle_vec[i]),
         .load      (load),
         .load_data (load_val[i]),
         .q         (count_q[i])
      );
   end

   // Flag next state: tc mirrors this cycle's limit event; a limit event
   // takes precedence over clr_ovf so an overflow is never lost.
   always_comb begin
      tc_d  = limit_event;
      ovf_d = ovf_q;
      if (limit_event) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Flag registers share the counter's asynchronous clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = count_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_modulo_contador_param_up_down_mod.sv
// ---------------------------------------------------------------------------
// tb_modulo_contador_param_up_down_mod
// Drives two counters side by side from the same inputs: one with a short
// modulus (MAX_COUNT=99) and one using the full 7-bit range (127). A small
// integer model predicts each counter; predictions are queued when stimulus
// is applied and compared once the edge has produced the outputs.
// ---------------------------------------------------------------------------
module tb_modulo_contador_param_up_down_mod;

   typedef struct {
      int idx;
      int q;
      int tc;
      int ovf;
   } exp_t;

   logic       clk;
   logic       clr;
   logic       enable;
   logic       upDown;
   logic       load;
   logic [6:0] eLoad;
   logic       satMode;
   logic       clrOvf;

   logic [6:0] qOut     [2];
   logic       tcOut    [2];
   logic       atLimOut [2];
   logic       ovfOut   [2];

   int   maxV [2];
   int   mQ   [2];
   int   mTc  [2];
   int   mOvf [2];

   exp_t  sbQueue[$];
   string curTag;
   int    checkCount;
   int    passCount;

   modulo_contador_param_up_down_mod #(
      .WIDTH       (7),
      .MAX_COUNT   (99),
      .RESET_VALUE (0)
   ) dutMod99 (
      .clk      (clk),
      .clr      (clr),
      .enable   (enable),
      .up_down  (upDown),
      .load     (load),
      .e_load   (eLoad),
      .sat_mode (satMode),
      .clr_ovf  (clrOvf),
      .q        (qOut[0]),
      .tc       (tcOut[0]),
      .at_limit (atLimOut[0]),
      .ovf      (ovfOut[0])
   );

   modulo_contador_param_up_down_mod #(
      .WIDTH (7)
   ) dutFull (
      .clk      (clk),
      .clr      (clr),
      .enable   (enable),
      .up_down  (upDown),
      .load     (load),
      .e_load   (eLoad),
      .sat_mode (satMode),
      .clr_ovf  (clrOvf),
      .q        (qOut[1]),
      .tc       (tcOut[1]),
      .at_limit (atLimOut[1]),
      .ovf      (ovfOut[1])
   );

   // Free-running 10-unit clock; stimulus changes on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic drainScoreboard();
      exp_t e;
      int   expLim;
      while (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         expLim = upDown ? int'(e.q == maxV[e.idx]) : int'(e.q == 0);
         checkOutput($sformatf("%s.d%0d.q",   curTag, e.idx), int'(qOut[e.idx]),     e.q);
         checkOutput($sformatf("%s.d%0d.tc",  curTag, e.idx), int'(tcOut[e.idx]),    e.tc);
         checkOutput($sformatf("%s.d%0d.ovf", curTag, e.idx), int'(ovfOut[e.idx]),   e.ovf);
         checkOutput($sformatf("%s.d%0d.lim", curTag, e.idx), int'(atLimOut[e.idx]), expLim);
      end
   endtask

   // Called at a falling edge: drive one cycle of inputs, predict both
   // counters, let the rising edge happen, then compare.
   task automatic applyStimulus(input string tag, input logic ld, input int ev,
                                input logic en, input logic ud, input logic sat,
                                input logic cov);
      int limit;
      curTag  = tag;
      load    = ld;
      eLoad   = 7'(ev);
      enable  = en;
      upDown  = ud;
      satMode = sat;
      clrOvf  = cov;
      for (int k = 0; k < 2; k++) begin
         limit = 0;
         if (ld) begin
            mQ[k] = (ev > maxV[k]) ? maxV[k] : ev;
         end else if (en) begin
            if (ud) begin
               if (mQ[k] == maxV[k]) begin
                  limit = 1;
                  if (!sat) mQ[k] = 0;
               end else begin
                  mQ[k] = mQ[k] + 1;
               end
            end else begin
               if (mQ[k] == 0) begin
                  limit = 1;
                  if (!sat) mQ[k] = maxV[k];
               end else begin
                  mQ[k] = mQ[k] - 1;
               end
            end
         end
         mTc[k] = limit;
         if (limit != 0) mOvf[k] = 1;
         else if (cov) mOvf[k] = 0;
         sbQueue.push_back('{k, mQ[k], mTc[k], mOvf[k]});
      end
      @(posedge clk);
      #1;
      drainScoreboard();
      @(negedge clk);
   endtask

   // Asserts clr between edges and checks the outputs clear without a clock;
   // releases clr at the next falling edge.
   task automatic doReset(input string tag);
      #2;
      clr     = 1'b0;
      load    = 1'b0;
      enable  = 1'b0;
      upDown  = 1'b0;
      satMode = 1'b0;
      clrOvf  = 1'b0;
      eLoad   = '0;
      for (int k = 0; k < 2; k++) begin
         mQ[k]   = 0;
         mTc[k]  = 0;
         mOvf[k] = 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("%s.d%0d.q",   tag, k), int'(qOut[k]),     0);
         checkOutput($sformatf("%s.d%0d.tc",  tag, k), int'(tcOut[k]),    0);
         checkOutput($sformatf("%s.d%0d.ovf", tag, k), int'(ovfOut[k]),   0);
         checkOutput($sformatf("%s.d%0d.lim", tag, k), int'(atLimOut[k]), 1);
      end
      @(negedge clk);
      clr = 1'b1;
   endtask

   // Main sequence: directed scenarios first, then a short random soak.
   initial begin
      checkCount = 0;
      passCount  = 0;
      maxV[0]    = 99;
      maxV[1]    = 127;
      clr        = 1'b1;

      doReset("por");

      // First edge after release counts, then build up to 37 and reset mid-count.
      applyStimulus("rel_up", 0, 0, 1, 1, 0, 0);
      applyStimulus("ld30",   1, 30, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) applyStimulus("up_to37", 0, 0, 1, 1, 0, 0);
      doReset("rst37");
      applyStimulus("rel_up1", 0, 0, 1, 1, 0, 0);

      // Wrap upward at 99.
      applyStimulus("ld98", 1, 98, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("wrap_up", 0, 0, 1, 1, 0, 0);

      // clr_ovf on its own clears the sticky flag.
      applyStimulus("clrovf", 0, 0, 0, 1, 0, 1);

      // Wrap downward past 0.
      applyStimulus("ld1", 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("wrap_dn", 0, 0, 1, 0, 0, 0);

      // clr_ovf coincident with a wrap: the event keeps ovf set.
      applyStimulus("clrovf2", 0, 0, 0, 0, 0, 1);
      applyStimulus("ld0",     1, 0, 0, 0, 0, 0);
      applyStimulus("wrap_cov", 0, 0, 1, 0, 0, 1);

      // Saturate at the top, repeated tc while pinned, then step back down.
      applyStimulus("ld126", 1, 126, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus("sat_up", 0, 0, 1, 1, 1, 0);
      applyStimulus("sat_dn", 0, 0, 1, 0, 1, 0);

      // Saturate at the bottom.
      applyStimulus("ld0b", 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) applyStimulus("sat_bot", 0, 0, 1, 0, 1, 0);

      // Load priority over enable, clamping, load while disabled, hold.
      applyStimulus("ld120_en", 1, 120, 1, 1, 0, 0);
      applyStimulus("ld5_dis",  1, 5,   0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus("hold", 0, 77, 0, i[0], 0, 0);

      // Random soak across all controls.
      for (int i = 0; i < 60; i++) begin
         applyStimulus("rand",
                       ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 127)),
                       ($urandom_range(0, 4) != 0),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
